mem_wb: RTL and testbench
=========================

Name: mem_wb

Overview:
- Memory-access / writeback-producer stage of the 64-bit RV64IM pipeline.
- Accepts one retiring instruction per cycle from execute: ALU result, store data, rd and control bits.
- Performs loads and stores over a valid/ready data-memory port, formats load data, and drives the writeback interface (enableW, RdW, RegWriteW, ResultW) that the register-file write port consumes.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- DMEM_AW, 64: width of dmem_req_addr. Address is the low DMEM_AW bits of ALUResultM, with bits [2:0] forced to 0.
- WB_HOLD, 0: reserved. Must be 0. Writeback is always a single-cycle pulse.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- enableM  in  1  instruction valid from execute.
- ALUResultM  in  64  ALU result, or effective address for loads and stores.
- WriteDataM  in  64  store data (rs2).
- PCPlus4M  in  64  PC+4 for jal/jalr.
- RdM  in  5  destination register.
- RegWriteM  in  1  register write request.
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4.
- MemWriteM  in  1  store.
- funct3M  in  3  access size and sign.
- stallM  out  1  upstream must hold its inputs stable.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_addr  out  DMEM_AW  8-byte-aligned address.
- dmem_req_write  out  1  1 = store.
- dmem_req_wdata  out  64  lane-shifted store data.
- dmem_req_wstrb  out  8  byte enables.
- dmem_resp_valid  in  1  load data valid; single-cycle pulse.
- dmem_resp_data  in  64  aligned 8-byte load data.
- enableW  out  1  writeback valid pulse.
- RdW  out  5  writeback rd.
- RegWriteW  out  1  writeback write enable.
- ResultW  out  64  writeback value.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE.
  - enableW, RegWriteW, dmem_req_valid, dmem_req_write = 0.
  - RdW, ResultW, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb = 0.
  - Reset mid-transaction abandons the transaction. A dmem_resp_valid arriving after reset is ignored in IDLE.
- Instruction classes:
  - mem op = enableM & (ResultSrcM==01 | MemWriteM).
  - non-mem = enableM & !mem op.
- Non-mem path (IDLE only), 1-cycle latency, registered:
  - Next cycle: enableW=1, RdW=RdM, RegWriteW=RegWriteM & (RdM!=0).
  - ResultW = PCPlus4M if ResultSrcM==10, else ALUResultM.
  - Back-to-back non-mem ops retire one per cycle.
- FSM states IDLE, REQ, WAIT:
  - IDLE, mem op: capture address, data, funct3, rd and control; go to REQ. dmem_req_valid=1 from the next cycle.
  - REQ: hold dmem_req_* stable until dmem_req_ready.
    - Accepted store: go to IDLE and pulse enableW with RegWriteW=0 in the following cycle.
    - Accepted load: go to WAIT.
  - WAIT: on dmem_resp_valid, pulse enableW next cycle with formatted load data, RegWriteW = captured RegWrite & (rd!=0); go to IDLE.
  - A dmem_resp_valid in the same cycle as req acceptance is not legal; the memory responds at least 1 cycle later.
- stallM = (state!=IDLE) | (state==IDLE & mem op). It drops the cycle the FSM returns to IDLE, so the next instruction is accepted that cycle. While stallM=1, enableM and data inputs are ignored.
- enableW is high exactly one cycle per retired instruction and 0 otherwise.
  - RdW and ResultW hold their last values when enableW=0.
- Lanes: off = ALUResultM[2:0].
  - Store strobes: sb 0x01<<off, sh 0x03<<off, sw 0x0F<<off, sd 0xFF.
  - Store data: wdata = WriteDataM<<(8*off).
  - Load: data = dmem_resp_data>>(8*off), then by funct3: 000 lb sign-ext 8, 001 lh sign-ext 16, 010 lw sign-ext 32, 011 ld, 100 lbu, 101 lhu, 110 lwu zero-ext. funct3 111 yields 0.
- Misaligned accesses (access crossing an 8-byte boundary) without the optional feature: low lanes are used and upper bytes are dropped. No error is raised.

Optional Feature:
- Macro: MEM_WB_MISALIGN_TRAP_EN.
- Defined: adds output misalignW (1 bit, reset 0).
  - A mem op with off not a multiple of its size issues no dmem request.
  - It retires 1 cycle later with enableW=1, RegWriteW=0, misalignW=1 (single-cycle pulse), ResultW=ALUResultM (faulting address).
  - stallM is asserted only in the accept cycle.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-WAIT -> all outputs 0, state IDLE. A late dmem_resp_valid produces no enableW.
- Non-mem back-to-back: addi results 5, 7 to rd=3, 4 on consecutive cycles -> enableW high for 2 cycles with (3,5), (4,7).
  - Same test with rd=0 -> RegWriteW=0.
- Load lb: addr 0x1003, resp data 0x0000_0000_80FF_0000 -> wstrb unused, dmem_req_addr=0x1000, ResultW=0xFFFF_FFFF_FFFF_FF80.
  - Same access as lbu -> 0x80.
- Store sh with ready delayed 3 cycles: addr 0x2006, data 0xBEEF -> wstrb=0xC0, wdata=0xBEEF<<48.
  - valid and payload held stable for 3 cycles; stallM high throughout; enableW pulse with RegWriteW=0.
- jal: ResultSrcM=10, PCPlus4M=0x8000_0004, rd=1 -> ResultW=0x8000_0004 after 1 cycle, no dmem request.
- MEM_WB_MISALIGN_TRAP_EN: lw at 0x1002 -> no dmem_req_valid; misalignW=1, ResultW=0x1002, RegWriteW=0.

Source files
------------

// File: rtl/mem_wb.sv
// mem_wb: memory-access / writeback-producer stage of the RV64IM pipeline.
// Takes one instruction per cycle from execute. Non-memory ops retire one
// cycle later. Loads and stores go out over a valid/ready data-memory port
// through a small IDLE/REQ/WAIT FSM, which stalls upstream meanwhile.
// Optional build macro: MEM_WB_MISALIGN_TRAP_EN adds the misalignW output.
// With it, misaligned memory ops retire as a trap instead of issuing a request.
`timescale 1ns/1ps
module mem_wb #(
    parameter int DMEM_AW = 64,
    parameter int WB_HOLD = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enableM,
    input  logic [63:0]        ALUResultM,
    input  logic [63:0]        WriteDataM,
    input  logic [63:0]        PCPlus4M,
    input  logic [4:0]         RdM,
    input  logic               RegWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic               MemWriteM,
    input  logic [2:0]         funct3M,
    output logic               stallM,
    output logic               dmem_req_valid,
    input  logic               dmem_req_ready,
    output logic [DMEM_AW-1:0] dmem_req_addr,
    output logic               dmem_req_write,
    output logic [63:0]        dmem_req_wdata,
    output logic [7:0]         dmem_req_wstrb,
    input  logic               dmem_resp_valid,
    input  logic [63:0]        dmem_resp_data,
    output logic               enableW,
    output logic [4:0]         RdW,
    output logic               RegWriteW,
    output logic [63:0]        ResultW
`ifdef MEM_WB_MISALIGN_TRAP_EN
    ,
    output logic               misalignW
`endif
);

    // Writeback is always a single-cycle pulse; no other hold length exists.
    if (WB_HOLD != 0) begin : g_wb_hold_check
        $error("mem_wb: WB_HOLD must be 0");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [DMEM_AW-1:0] addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         wstrb_q, wstrb_d;
    logic               write_q, write_d;
    logic [2:0]         f3_q, f3_d;
    logic [2:0]         off_q, off_d;
    logic [4:0]         rd_q, rd_d;
    logic               rw_q, rw_d;
    logic               enw_q, enw_d;
    logic [4:0]         rdw_q, rdw_d;
    logic               rww_q, rww_d;
    logic [63:0]        resw_q, resw_d;

    logic               mem_op;
    logic               non_mem;
    logic               trap;
    logic [2:0]         off_m;

    // Byte enables for an access of size funct3[1:0] starting at lane off.
    // Lanes above byte 7 fall off the top (misaligned upper bytes dropped).
    function automatic logic [7:0] lane_strb(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b00:   lane_strb = 8'h01 << off;
            2'b01:   lane_strb = 8'h03 << off;
            2'b10:   lane_strb = 8'h0F << off;
            default: lane_strb = 8'hFF;
        endcase
    endfunction

    // Bring the addressed lane down to bit 0, then size and extend it.
    function automatic logic [63:0] fmt_load(input logic [63:0] raw, input logic [2:0] off,
                                             input logic [2:0] f3);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{56{sh[7]}}, sh[7:0]};
            3'b001:  fmt_load = {{48{sh[15]}}, sh[15:0]};
            3'b010:  fmt_load = {{32{sh[31]}}, sh[31:0]};
            3'b011:  fmt_load = sh;
            3'b100:  fmt_load = {56'd0, sh[7:0]};
            3'b101:  fmt_load = {48'd0, sh[15:0]};
            3'b110:  fmt_load = {32'd0, sh[31:0]};
            default: fmt_load = 64'd0;
        endcase
    endfunction

    assign off_m   = ALUResultM[2:0];
    assign mem_op  = enableM & ((ResultSrcM == 2'b01) | MemWriteM);
    assign non_mem = enableM & ~mem_op;

`ifdef MEM_WB_MISALIGN_TRAP_EN
    // Offset must be a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = |off[1:0];
            default: is_misaligned = |off;
        endcase
    endfunction

    assign trap = mem_op & is_misaligned(funct3M, off_m);
`else
    assign trap = 1'b0;
`endif

    // Memory handshake: a request is transferred on the rising edge where
    // dmem_req_valid and dmem_req_ready are both 1; while valid is high and
    // ready is low, addr/write/wdata/wstrb stay constant. A load response is
    // a one-cycle dmem_resp_valid pulse, at least one cycle after acceptance,
    // and is only consumed in WAIT.
    assign dmem_req_valid = (state_q == REQ);
    assign dmem_req_addr  = addr_q;
    assign dmem_req_write = write_q;
    assign dmem_req_wdata = wdata_q;
    assign dmem_req_wstrb = wstrb_q;

    // Upstream holds while a transaction is open or is being accepted now.
    assign stallM = (state_q != IDLE) | ((state_q == IDLE) & mem_op);

    assign enableW   = enw_q;
    assign RdW       = rdw_q;
    assign RegWriteW = rww_q;
    assign ResultW   = resw_q;

    // Next-state, request capture and writeback formation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        write_d = write_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        enw_d   = 1'b0;
        rdw_d   = rdw_q;
        rww_d   = 1'b0;
        resw_d  = resw_q;
        case (state_q)
            IDLE: begin
                if (trap) begin
                    enw_d  = 1'b1;
                    rdw_d  = RdM;
                    resw_d = ALUResultM;
                end else if (mem_op) begin
                    addr_d  = {ALUResultM[DMEM_AW-1:3], 3'b000};
                    wdata_d = WriteDataM << {off_m, 3'b000};
                    wstrb_d = MemWriteM ? lane_strb(funct3M, off_m) : 8'h00;
                    write_d = MemWriteM;
                    f3_d    = funct3M;
                    off_d   = off_m;
                    rd_d    = RdM;
                    rw_d    = RegWriteM;
                    state_d = REQ;
                end else if (non_mem) begin
                    enw_d  = 1'b1;
                    rdw_d  = RdM;
                    rww_d  = RegWriteM & (RdM != 5'd0);
                    resw_d = (ResultSrcM == 2'b10) ? PCPlus4M : ALUResultM;
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    if (write_q) begin
                        enw_d   = 1'b1;
                        rdw_d   = rd_q;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_resp_valid) begin
                    enw_d   = 1'b1;
                    rdw_d   = rd_q;
                    rww_d   = rw_q & (rd_q != 5'd0);
                    resw_d  = fmt_load(dmem_resp_data, off_q, f3_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            enw_q   <= 1'b0;
            rdw_q   <= '0;
            rww_q   <= 1'b0;
            resw_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            enw_q   <= enw_d;
            rdw_q   <= rdw_d;
            rww_q   <= rww_d;
            resw_q  <= resw_d;
        end
    end

`ifdef MEM_WB_MISALIGN_TRAP_EN
    logic misal_q;

    assign misalignW = misal_q;

    // One-cycle flag that accompanies the trap writeback.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            misal_q <= 1'b0;
        end else begin
            misal_q <= (state_q == IDLE) & trap;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed bench for mem_wb. The bench acts as execute and as the
// data memory. A queue of expected writebacks comes from a byte-level model of
// the lane/extension rules. A negedge compare process checks every cycle.
`timescale 1ns/1ps
module tb_mem_wb;

    localparam int W = 72; // {chk_id, misalign, regwrite, rd[4:0], result[63:0]}

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enableM;
    logic [63:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic        stallM;
    logic        dmem_req_valid, dmem_req_ready;
    logic [63:0] dmem_req_addr;
    logic        dmem_req_write;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_data;
    logic        enableW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [63:0] ResultW;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    logic        misalignW;
`endif

    mem_wb #(.DMEM_AW(64), .WB_HOLD(0)) dut (
        .clk(clk), .reset_n(reset_n), .enableM(enableM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .funct3M(funct3M), .stallM(stallM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_write(dmem_req_write),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .enableW(enableW), .RdW(RdW), .RegWriteW(RegWriteW), .ResultW(ResultW)
`ifdef MEM_WB_MISALIGN_TRAP_EN
        , .misalignW(misalignW)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    logic [4:0]   last_rd  = '0;
    logic [63:0]  last_res = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model ----------------
    function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [2:0] off);
        int sz;
        logic [7:0] s;
        sz = 1 << f3[1:0];
        s = 8'h00;
        if (sz == 8) return 8'hFF;
        for (int b = 0; b < 8; b++)
            if (b >= int'(off) && b < int'(off) + sz) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [2:0] off);
        logic [63:0] v;
        v = '0;
        for (int b = int'(off); b < 8; b++) v[8*b +: 8] = wd[8*(b - int'(off)) +: 8];
        return v;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] data, input logic [2:0] off,
                                           input logic [2:0] f3);
        int sz;
        logic [63:0] v;
        if (f3 == 3'b111) return 64'd0;
        sz = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < sz; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = data[8*(int'(off) + i) +: 8];
        if (!f3[2] && sz < 8 && v[8*sz - 1])
            for (int b = 8*sz; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input logic chk_id, input logic mis, input logic rw,
                            input logic [4:0] rd, input logic [63:0] res, input int due);
        exp_q.push_back({chk_id, mis, rw, rd, res});
        due_q.push_back(due);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        int d;
        if (reset_n) begin
            if (enableW) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", enableW, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    chk("wb_cycle", 64'(cyc), 64'(d));
                    chk("wb_regwrite", RegWriteW, e[69]);
`ifdef MEM_WB_MISALIGN_TRAP_EN
                    chk("wb_misalign", misalignW, e[70]);
`endif
                    if (e[71]) begin
                        chk("wb_rd", RdW, e[68:64]);
                        chk("wb_result", ResultW, e[63:0]);
                        last_rd  = e[68:64];
                        last_res = e[63:0];
                    end else begin
                        last_rd  = RdW;
                        last_res = ResultW;
                    end
                end
            end else begin
                chk("hold_rd", RdW, last_rd);
                chk("hold_result", ResultW, last_res);
`ifdef MEM_WB_MISALIGN_TRAP_EN
                chk("idle_misalign", misalignW, 1'b0);
`endif
                if (due_q.size() != 0 && due_q[0] < cyc) begin
                    chk("wb_missing", enableW, 1'b1);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enableW"}, enableW, 1'b0);
        chk({tag, "_RegWriteW"}, RegWriteW, 1'b0);
        chk({tag, "_RdW"}, RdW, 5'd0);
        chk({tag, "_ResultW"}, ResultW, 64'd0);
        chk({tag, "_req_valid"}, dmem_req_valid, 1'b0);
        chk({tag, "_req_write"}, dmem_req_write, 1'b0);
        chk({tag, "_req_addr"}, dmem_req_addr, 64'd0);
        chk({tag, "_req_wdata"}, dmem_req_wdata, 64'd0);
        chk({tag, "_req_wstrb"}, dmem_req_wstrb, 8'd0);
        chk({tag, "_stallM"}, stallM, 1'b0);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                          input logic [63:0] alu, input logic [63:0] pc);
        enableM = 1'b1; ALUResultM = alu; PCPlus4M = pc; RdM = rd; RegWriteM = rw;
        ResultSrcM = src; MemWriteM = 1'b0; funct3M = 3'($urandom_range(0, 7));
        WriteDataM = {$urandom, $urandom};
        push_exp(1'b1, 1'b0, rw && (rd != 5'd0), rd, (src == 2'b10) ? pc : alu, cyc + 1);
        #1;
        chk("alu_stall", stallM, 1'b0);
        tick();
        enableM = 1'b0;
        chk("alu_no_req", dmem_req_valid, 1'b0);
    endtask

    // One load or store end to end; leaves time just after the retire edge.
    task automatic mem_op(input logic [63:0] addr, input logic [63:0] wd, input logic [2:0] f3,
                          input logic st, input logic [4:0] rd, input logic rw,
                          input int rdy_dly, input int rsp_dly, input logic [63:0] rdata);
        logic [63:0] e_addr, e_wd;
        logic [7:0]  e_strb;
        e_addr = {addr[63:3], 3'b000};
        e_strb = m_strb(f3, addr[2:0]);
        e_wd   = m_wdata(wd, addr[2:0]);
        enableM = 1'b1; ALUResultM = addr; WriteDataM = wd; funct3M = f3; MemWriteM = st;
        ResultSrcM = st ? 2'b00 : 2'b01; RdM = rd; RegWriteM = rw; PCPlus4M = {$urandom, $urandom};
        #1;
        chk("accept_stall", stallM, 1'b1);
        chk("accept_no_valid", dmem_req_valid, 1'b0);
        tick();
        // Inputs are ignored while stalled; scramble them.
        ALUResultM = {$urandom, $urandom}; WriteDataM = {$urandom, $urandom};
        funct3M = 3'($urandom_range(0, 7)); RdM = 5'($urandom_range(0, 31));
        enableM = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i != 0) tick();
            chk("req_valid", dmem_req_valid, 1'b1);
            chk("req_addr", dmem_req_addr, e_addr);
            chk("req_write", dmem_req_write, st);
            if (st) begin
                chk("req_wstrb", dmem_req_wstrb, e_strb);
                chk("req_wdata", dmem_req_wdata, e_wd);
            end
            chk("req_stall", stallM, 1'b1);
        end
        dmem_req_ready = 1'b1;
        if (st) push_exp(1'b0, 1'b0, 1'b0, rd, 64'd0, cyc + 1);
        tick();
        dmem_req_ready = 1'b0;
        chk("post_accept_valid", dmem_req_valid, 1'b0);
        if (!st) begin
            chk("wait_stall", stallM, 1'b1);
            for (int i = 1; i < rsp_dly; i++) begin
                tick();
                chk("wait_stall", stallM, 1'b1);
            end
            dmem_resp_valid = 1'b1;
            dmem_resp_data  = rdata;
            push_exp(1'b1, 1'b0, rw && (rd != 5'd0), rd, m_load(rdata, addr[2:0], f3), cyc + 1);
            tick();
            dmem_resp_valid = 1'b0;
            dmem_resp_data  = {$urandom, $urandom};
        end
        chk("retire_enableW", enableW, 1'b1);
        chk("retire_stall", stallM, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; enableM = 1'b0; ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0;
        RdM = '0; RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; funct3M = '0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Non-mem back-to-back: (3,5) then (4,7).
        alu_op(5'd3, 1'b1, 2'b00, 64'd5, 64'h100);
        chk("b2b_a_en", enableW, 1'b1);
        chk("b2b_a_rd", RdW, 5'd3);
        chk("b2b_a_res", ResultW, 64'd5);
        chk("b2b_a_rw", RegWriteW, 1'b1);
        alu_op(5'd4, 1'b1, 2'b00, 64'd7, 64'h104);
        chk("b2b_b_en", enableW, 1'b1);
        chk("b2b_b_rd", RdW, 5'd4);
        chk("b2b_b_res", ResultW, 64'd7);
        tick();
        chk("b2b_end_en", enableW, 1'b0);

        // Same with rd=0: no register write.
        alu_op(5'd0, 1'b1, 2'b00, 64'd5, 64'h108);
        chk("rd0_rw", RegWriteW, 1'b0);
        alu_op(5'd0, 1'b1, 2'b00, 64'd7, 64'h10C);
        chk("rd0_rw2", RegWriteW, 1'b0);
        tick();

        // jal: result is PC+4.
        alu_op(5'd1, 1'b1, 2'b10, 64'h1234, 64'h8000_0004);
        chk("jal_res", ResultW, 64'h8000_0004);
        chk("jal_rd", RdW, 5'd1);
        tick();

        // lb / lbu at 0x1003.
        mem_op(64'h1003, 64'd0, 3'b000, 1'b0, 5'd5, 1'b1, 0, 1, 64'h0000_0000_80FF_0000);
        chk("lb_res", ResultW, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op(64'h1003, 64'd0, 3'b100, 1'b0, 5'd6, 1'b1, 1, 2, 64'h0000_0000_80FF_0000);
        chk("lbu_res", ResultW, 64'h80);
        tick();

        // sh at 0x2006 with ready delayed 3 cycles.
        mem_op(64'h2006, 64'hBEEF, 3'b001, 1'b1, 5'd0, 1'b0, 3, 0, 64'd0);
        chk("sh_rw", RegWriteW, 1'b0);
        tick();

        // Remaining sizes, back-to-back with the retire cycle.
        mem_op(64'h2003, 64'hA5, 3'b000, 1'b1, 5'd0, 1'b0, 0, 0, 64'd0);
        mem_op(64'h2004, 64'h1122_3344, 3'b010, 1'b1, 5'd0, 1'b0, 2, 0, 64'd0);
        mem_op(64'h3000, 64'hDEAD_BEEF_CAFE_F00D, 3'b011, 1'b1, 5'd0, 1'b0, 1, 0, 64'd0);
        mem_op(64'h1006, 64'd0, 3'b001, 1'b0, 5'd7, 1'b1, 0, 3, 64'h8001_0000_0000_0000);
        chk("lh_res", ResultW, 64'hFFFF_FFFF_FFFF_8001);
        mem_op(64'h1006, 64'd0, 3'b101, 1'b0, 5'd8, 1'b1, 0, 1, 64'h8001_0000_0000_0000);
        mem_op(64'h1004, 64'd0, 3'b010, 1'b0, 5'd9, 1'b1, 1, 1, 64'hF000_0001_0000_0000);
        chk("lw_res", ResultW, 64'hFFFF_FFFF_F000_0001);
        mem_op(64'h1004, 64'd0, 3'b110, 1'b0, 5'd10, 1'b1, 0, 2, 64'hF000_0001_0000_0000);
        mem_op(64'h1000, 64'd0, 3'b011, 1'b0, 5'd11, 1'b1, 0, 1, 64'h0123_4567_89AB_CDEF);
        mem_op(64'h1000, 64'd0, 3'b111, 1'b0, 5'd12, 1'b1, 0, 1, 64'h0123_4567_89AB_CDEF);
        chk("f3_111_res", ResultW, 64'd0);
        mem_op(64'h1000, 64'd0, 3'b011, 1'b0, 5'd0, 1'b1, 0, 1, 64'h55);
        chk("load_rd0_rw", RegWriteW, 1'b0);
        alu_op(5'd13, 1'b1, 2'b00, 64'h77, 64'h200);
        tick();

`ifdef MEM_WB_MISALIGN_TRAP_EN
        // Misaligned lw traps without a memory request.
        enableM = 1'b1; ALUResultM = 64'h1002; funct3M = 3'b010; ResultSrcM = 2'b01;
        MemWriteM = 1'b0; RdM = 5'd14; RegWriteM = 1'b1;
        push_exp(1'b1, 1'b1, 1'b0, 5'd14, 64'h1002, cyc + 1);
        #1;
        chk("trap_accept_stall", stallM, 1'b1);
        tick();
        enableM = 1'b0;
        chk("trap_no_req", dmem_req_valid, 1'b0);
        chk("trap_misalignW", misalignW, 1'b1);
        chk("trap_res", ResultW, 64'h1002);
        chk("trap_rw", RegWriteW, 1'b0);
        chk("trap_stall", stallM, 1'b0);
        tick();
`else
        // Misaligned lw: upper bytes dropped.
        mem_op(64'h1006, 64'd0, 3'b010, 1'b0, 5'd14, 1'b1, 0, 1, 64'h8765_4321_0000_0000);
        chk("misaligned_lw_res", ResultW, 64'h8765);
        tick();
`endif

        // Reset mid-WAIT, then a late response must be ignored.
        enableM = 1'b1; ALUResultM = 64'h1008; funct3M = 3'b011; ResultSrcM = 2'b01;
        MemWriteM = 1'b0; RdM = 5'd15; RegWriteM = 1'b1;
        tick();
        enableM = 1'b0;
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("pre_reset_wait_stall", stallM, 1'b1);
        reset_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        last_rd = '0;
        last_res = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs("midwait_reset");
        end
        reset_n = 1'b1;
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h1111_2222_3333_4444;
        tick();
        dmem_resp_valid = 1'b0;
        tick();
        chk("late_resp_no_wb", enableW, 1'b0);
        chk("late_resp_stall", stallM, 1'b0);

        // Post-reset sanity.
        alu_op(5'd2, 1'b1, 2'b00, 64'hABC, 64'h300);
        chk("post_reset_res", ResultW, 64'hABC);
        repeat (3) tick();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
